// File: rtl/store_align_unit_pkg.sv
// store_align_unit_pkg: store-mode encodings, FSM states and lane-mask helper.
package store_align_unit_pkg;
    localparam logic [1:0] ST_NOSTORE = 2'd0;
    localparam logic [1:0] ST_SB      = 2'd1;
    localparam logic [1:0] ST_SH      = 2'd2;
    localparam logic [1:0] ST_SW      = 2'd3;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] t);
        return t == ST_SW ? 4'b1111 : t == ST_SH ? 4'b0011 : t == ST_SB ? 4'b0001 : 4'b0000;
    endfunction
endpackage

// File: rtl/store_align_unit_lane_shift.sv
// store_align_unit_lane_shift: places store data and lane mask across a two-word window.
module store_align_unit_lane_shift
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    output logic [63:0] d64,
    output logic [7:0]  m8
);
    logic [3:0]  mask;
    logic [31:0] wdm;
    always_comb begin
        mask = lane_mask(store_type);
        wdm  = wd & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        d64  = {32'h0, wdm} << {off, 3'b000};
        m8   = {4'h0, mask} << off;
    end
endmodule

// File: rtl/store_align_unit.sv
// store_align_unit: aligns SB/SH/SW stores into word writes, splitting word-crossing stores in two beats.
module store_align_unit
    import store_align_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  StoreType,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic        MemValid,
    input  logic        MemReady,
    output logic [29:0] MemAddr,
    output logic [3:0]  MemWE,
    output logic [31:0] MemWD,
    output logic [15:0] SplitCnt
);
    state_t      state, nxt;
    logic [63:0] d64;
    logic [7:0]  m8;
    logic        go, split_q;
    logic [29:0] hi_addr;
    logic [3:0]  hi_we;
    logic [31:0] hi_wd;

    store_align_unit_lane_shift u_shift (
        .store_type(StoreType),
        .off       (Addr[1:0]),
        .wd        (WD),
        .d64       (d64),
        .m8        (m8)
    );

    assign go = ReqValid && ReqReady && StoreType != ST_NOSTORE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (go) nxt = BEAT0;
            BEAT0:   if (MemReady) nxt = split_q ? BEAT1 : IDLE;
            BEAT1:   if (MemReady) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ReqReady <= 1'b1;
            MemValid <= 1'b0;
        end else begin
            state    <= nxt;
            ReqReady <= nxt == IDLE;
            MemValid <= nxt != IDLE;
        end
    end

    // The upper half of the window is parked in hi_* until the first beat retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MemAddr  <= '0;
            MemWE    <= '0;
            MemWD    <= '0;
            hi_addr  <= '0;
            hi_we    <= '0;
            hi_wd    <= '0;
            split_q  <= 1'b0;
            SplitCnt <= '0;
        end else if (go) begin
            MemAddr <= Addr[31:2];
            MemWE   <= m8[3:0];
            MemWD   <= d64[31:0];
            hi_addr <= Addr[31:2] + 30'd1;
            hi_we   <= m8[7:4];
            hi_wd   <= d64[63:32];
            split_q <= |m8[7:4];
        end else if (state == BEAT0 && MemReady && split_q) begin
            MemAddr  <= hi_addr;
            MemWE    <= hi_we;
            MemWD    <= hi_wd;
            SplitCnt <= SplitCnt + 16'd1;
        end else if (state != IDLE && MemReady) begin
            MemAddr <= '0;
            MemWE   <= '0;
            MemWD   <= '0;
        end
    end
endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: byte-wise store model with per-cycle beat checks plus literal beat expectations.
module tb_store_align_unit;
    logic        clk = 0, rst_n = 0, ReqValid = 0, MemReady = 1;
    logic [1:0]  StoreType = 0;
    logic [31:0] Addr = 0, WD = 0;
    logic        ReqReady, MemValid;
    logic [29:0] MemAddr;
    logic [3:0]  MemWE;
    logic [31:0] MemWD;
    logic [15:0] SplitCnt;

    typedef struct packed {logic [29:0] a; logic [3:0] we; logic [31:0] wd;} beat_t;
    beat_t exp_q[$], got_q[$];
    int checks = 0, failures = 0, split_model = 0;

    store_align_unit dut (
        .clk(clk), .rst_n(rst_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .StoreType(StoreType), .Addr(Addr), .WD(WD), .MemValid(MemValid),
        .MemReady(MemReady), .MemAddr(MemAddr), .MemWE(MemWE), .MemWD(MemWD),
        .SplitCnt(SplitCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout/unexpected required=event", name);
    endtask

    // Each byte goes to address Addr+i; bytes sharing a word form one beat.
    task automatic model(input logic [1:0] t, input logic [31:0] addr, input logic [31:0] wd, output int n);
        beat_t cur[$];
        int nb = t == 1 ? 1 : t == 2 ? 2 : t == 3 ? 4 : 0;
        for (int i = 0; i < nb; i++) begin
            logic [31:0] a = addr + i;
            logic [7:0]  b = 8'((wd >> (8 * i)) & 32'hFF);
            if (cur.size() == 0 || cur[cur.size()-1].a != a[31:2])
                cur.push_back('{a: a[31:2], we: 4'b0, wd: 32'b0});
            cur[cur.size()-1].we[a[1:0]] = 1'b1;
            cur[cur.size()-1].wd[8*a[1:0] +: 8] = b;
        end
        n = cur.size();
        if (n == 2) split_model++;
        foreach (cur[i]) exp_q.push_back(cur[i]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (MemValid) begin
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    chk("beat", {MemAddr, MemWE, MemWD}, exp_q[0]);
                    chk("busy_ready", 66'(ReqReady), 66'd0);
                    if (MemReady) begin
                        got_q.push_back({MemAddr, MemWE, MemWD});
                        void'(exp_q.pop_front());
                    end
                end
            end else chk("idle_lanes", {MemWE, MemWD}, 66'd0);
        end
    end

    task automatic store(input logic [1:0] t, input logic [31:0] addr, input logic [31:0] wd, input int stall);
        int n, k = 0;
        while (!ReqReady && k < 50) begin @(posedge clk); #1; k++; end
        if (!ReqReady) fail_now("ready_timeout");
        got_q.delete();
        model(t, addr, wd, n);
        ReqValid = 1; StoreType = t; Addr = addr; WD = wd;
        @(posedge clk); #1;
        ReqValid = 0;
        if (stall > 0) begin
            for (int b = 0; b < n; b++) begin
                MemReady = 0;
                repeat (stall) begin
                    ReqValid = ~ReqValid; StoreType = 2'd3; Addr = $urandom;
                    @(posedge clk); #1;
                    chk("stall_ready", 66'(ReqReady), 66'd0);
                end
                ReqValid = 0; MemReady = 1;
                @(posedge clk); #1;
            end
        end else begin
            k = 0;
            while (exp_q.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
        end
        if (exp_q.size() != 0) begin fail_now("beat_timeout"); exp_q.delete(); end
        chk("done_ready", {ReqReady, MemValid}, 66'b10);
        chk("split_cnt", 66'(SplitCnt), 66'(split_model));
        chk("nbeats", 66'(got_q.size()), 66'(n));
    endtask

    task automatic lit(input string name, input int idx, input beat_t v);
        if (idx < got_q.size()) chk(name, got_q[idx], v);
        else fail_now(name);
    endtask

    initial begin
        #12;
        chk("rst_state", {ReqReady, MemValid, MemWE, MemWD, SplitCnt}, {1'b1, 1'b0, 4'h0, 32'h0, 16'h0});
        chk("rst_addr", 66'(MemAddr), 66'd0);
        rst_n = 1;
        @(posedge clk); #1;

        store(2'd1, 32'h0000_2003, 32'h1234_5678, 0);
        lit("sb_b0", 0, {30'h800, 4'b1000, 32'h7800_0000});
        store(2'd3, 32'h0000_1002, 32'hAABB_CCDD, 0);
        lit("sw_b0", 0, {30'h400, 4'b1100, 32'hCCDD_0000});
        lit("sw_b1", 1, {30'h401, 4'b0011, 32'h0000_AABB});
        store(2'd2, 32'h0000_0003, 32'h0000_BEEF, 0);
        lit("sh3_b0", 0, {30'h0, 4'b1000, 32'hEF00_0000});
        lit("sh3_b1", 1, {30'h1, 4'b0001, 32'h0000_00BE});
        store(2'd2, 32'h0000_0001, 32'h0000_BEEF, 0);
        lit("sh1_b0", 0, {30'h0, 4'b0110, 32'h00BE_EF00});
        store(2'd3, 32'hFFFF_FFFF, 32'h1122_3344, 0);
        lit("wrap_b0", 0, {30'h3FFF_FFFF, 4'b1000, 32'h4400_0000});
        lit("wrap_b1", 1, {30'h0, 4'b0111, 32'h0011_2233});
        store(2'd3, 32'h0000_0040, 32'hDEAD_BEEF, 0);
        lit("sw_al", 0, {30'h10, 4'b1111, 32'hDEAD_BEEF});
        store(2'd2, 32'h0000_0102, 32'hFFFF_1234, 0);
        store(2'd1, 32'h0000_0101, 32'hFFFF_FFA5, 0);
        store(2'd3, 32'h0000_0106, 32'hCAFE_F00D, 3);
        lit("stall_b0", 0, {30'h41, 4'b1100, 32'hF00D_0000});
        lit("stall_b1", 1, {30'h42, 4'b0011, 32'h0000_CAFE});

        store(2'd0, 32'h0000_0200, 32'h1111_1111, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("nostore", {ReqReady, MemValid}, 66'b10);
        end

        begin
            int n;
            model(2'd3, 32'h0000_1002, 32'hAABB_CCDD, n);
            ReqValid = 1; StoreType = 2'd3; Addr = 32'h0000_1002; WD = 32'hAABB_CCDD;
            @(posedge clk); #1;
            ReqValid = 0;
            @(posedge clk); #1;
            MemReady = 0;
            #2 rst_n = 0;
            #1;
            chk("rst_mid", {ReqReady, MemValid, MemWE, SplitCnt}, {1'b1, 1'b0, 4'h0, 16'h0});
            exp_q.delete();
            split_model = 0;
            @(negedge clk);
            rst_n = 1;
            MemReady = 1;
        end
        store(2'd1, 32'h0000_2003, 32'h1234_5678, 0);
        lit("post_rst", 0, {30'h800, 4'b1000, 32'h7800_0000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
